// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: bus widths, fetch FSM states and prefetch queue entry.
package cpu_pkg;

    localparam int ADDR_W   = 20;
    localparam int DATA_W   = 16;
    localparam int LONG_BIT = 15;

    typedef enum logic [1:0] {
        BOOT0,
        BOOT1,
        BOOT2,
        RUN
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-stage bundle: instruction-memory read port, redirect input and decode handshake.
interface instr_fetch_queue_if;
    import cpu_pkg::*;

    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [DATA_W-1:0] out_imm;
    logic              out_long;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output imem_rd, imem_addr, out_valid, out_instr, out_imm, out_long, out_pc,
        input  imem_data, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_rd, imem_addr, out_valid, out_instr, out_imm, out_long, out_pc,
        output imem_data, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {addr, word} entries with 1- or 2-entry pop and flush.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  fetch_entry_t      push_entry_i,
    input  logic              pop1_i,
    input  logic              pop2_i,
    input  logic              flush_i,
    output logic [CW-1:0]     count_o,
    output fetch_entry_t      head_o,
    output logic [DATA_W-1:0] head1_word_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    npop;

    assign npop = pop2_i ? 2'd2 : {1'b0, pop1_i};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PW'(1);
            rd_q  <= rd_q + PW'(npop);
            cnt_q <= cnt_q + CW'(push_i) - CW'(npop);
        end
    end

    // Storage needs no reset: entries are only observed below the count.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= push_entry_i;
    end

    assign count_o      = cnt_q;
    assign head_o       = mem_q[rd_q];
    assign head1_word_o = mem_q[rd_q + PW'(1)].word;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: boots the reset vector from words 0/1, then prefetches into a small queue
// and hands decode one whole (1- or 2-word) instruction per handshake.
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    instr_fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] vlow_q, vlow_d;
    logic              infl_q, infl_d;

    logic [CW-1:0]     count;
    fetch_entry_t      head, push_entry;
    logic [DATA_W-1:0] head1_word;
    logic              redir, fetch, head_long, vld, pop;

    assign redir      = bus.redirect_valid && (state_q == RUN);
    assign head_long  = head.word[LONG_BIT];
    assign vld        = !redir && (head_long ? (count >= CW'(2)) : (count >= CW'(1)));
    assign pop        = vld && bus.out_ready;
    // pc only moves past an in-flight read, so its address is always pc-1.
    assign push_entry = '{addr: pc_q - ADDR_W'(1), word: bus.imem_data};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (infl_q),
        .push_entry_i(push_entry),
        .pop1_i      (pop && !head_long),
        .pop2_i      (pop && head_long),
        .flush_i     (redir),
        .count_o     (count),
        .head_o      (head),
        .head1_word_o(head1_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT0;
            pc_q    <= '0;
            vlow_q  <= '0;
            infl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            vlow_q  <= vlow_d;
            infl_q  <= infl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        vlow_d  = vlow_q;
        infl_d  = 1'b0;
        fetch   = 1'b0;
        case (state_q)
            BOOT0: state_d = BOOT1;
            BOOT1: begin
                vlow_d  = bus.imem_data;
                state_d = BOOT2;
            end
            BOOT2: begin
                pc_d    = ADDR_W'({bus.imem_data, vlow_q});
                state_d = RUN;
            end
            RUN: begin
                // A redirect drops infl_d, so the read returning next cycle is never pushed.
                if (redir) begin
                    pc_d = bus.redirect_pc;
                end else if ((CW+1)'(count) + (CW+1)'(infl_q) < (CW+1)'(DEPTH)) begin
                    fetch  = 1'b1;
                    infl_d = 1'b1;
                    pc_d   = pc_q + ADDR_W'(1);
                end
            end
            default: state_d = BOOT0;
        endcase
    end

    assign bus.imem_rd   = rst && ((state_q == BOOT0) || (state_q == BOOT1) || fetch);
    assign bus.imem_addr = (state_q == BOOT1) ? ADDR_W'(1) : (fetch ? pc_q : '0);

    assign bus.out_valid = vld;
    assign bus.out_instr = vld ? head.word : '0;
    assign bus.out_imm   = (vld && head_long) ? head1_word : '0;
    assign bus.out_long  = vld && head_long;
    assign bus.out_pc    = vld ? head.addr : '0;

endmodule
